carfield_vip_req_mux: RTL and testbench

- Parametrised N-to-1 request multiplexer for Carfield verification/bring-up infrastructure. Successor to the fixed 4-port external-AXI-to-serial-link funnel.
- Merges NumPorts valid/ready request channels onto one master channel. Prefixes the port index onto the ID. Routes responses back by ID.
- Tracks outstanding transactions per port. Supports runtime-selectable round-robin or fixed-priority arbitration and a drain (quiesce) mode.

---
 rtl/carfield_vip_req_mux.sv | 145 ++++++++++++++
 tb/tb_carfield_vip_req_mux.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_vip_req_mux.sv
// N-to-1 valid/ready request funnel: the port index is prefixed onto the ID,
// responses are routed back by ID, and outstanding transactions are tracked per port.
module carfield_vip_req_mux #(
  parameter int NumPorts     = 4,
  parameter int IdWidth      = 4,
  parameter int AddrWidth    = 48,
  parameter int DataWidth    = 64,
  parameter int MaxTxns      = 8,
  parameter int PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  parameter int MstIdWidth   = IdWidth + PortIdxWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                arb_mode_i,
  input  logic                                drain_i,
  output logic                                drained_o,
  output logic                                err_o,
  input  logic [NumPorts-1:0]                 slv_req_valid_i,
  output logic [NumPorts-1:0]                 slv_req_ready_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  slv_req_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  slv_req_data_i,
  input  logic [NumPorts-1:0]                 slv_req_we_i,
  input  logic [NumPorts-1:0][IdWidth-1:0]    slv_req_id_i,
  output logic [NumPorts-1:0]                 slv_rsp_valid_o,
  input  logic [NumPorts-1:0]                 slv_rsp_ready_i,
  output logic [DataWidth-1:0]                slv_rsp_data_o,
  output logic [IdWidth-1:0]                  slv_rsp_id_o,
  output logic                                mst_req_valid_o,
  input  logic                                mst_req_ready_i,
  output logic [AddrWidth-1:0]                mst_req_addr_o,
  output logic [DataWidth-1:0]                mst_req_data_o,
  output logic                                mst_req_we_o,
  output logic [MstIdWidth-1:0]               mst_req_id_o,
  input  logic                                mst_rsp_valid_i,
  output logic                                mst_rsp_ready_o,
  input  logic [DataWidth-1:0]                mst_rsp_data_i,
  input  logic [MstIdWidth-1:0]               mst_rsp_id_i
);

  localparam int CntWidth = $clog2(MaxTxns + 1);

  logic [NumPorts-1:0][CntWidth-1:0] cnt;
  logic [PortIdxWidth-1:0]           rr_ptr;
  logic [NumPorts-1:0]               eligible;
  logic                              arb_en;
  logic                              gnt_valid;
  logic [PortIdxWidth-1:0]           gnt_idx;
  logic [PortIdxWidth-1:0]           rsp_idx;
  logic                              rsp_idx_ok;
  logic                              rsp_hs;
  logic                              all_idle;
  int                                cand;

  // Handshake: a transfer happens on any edge where valid && ready; valid never waits on ready.
  assign arb_en = !mst_req_valid_o || mst_req_ready_i;

  always_comb begin
    eligible = '0;
    all_idle = 1'b1;
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = slv_req_valid_i[p] && (cnt[p] < CntWidth'(MaxTxns)) && !drain_i;
      if (cnt[p] != '0) all_idle = 1'b0;
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (arb_en && !rst_i) begin
      for (int i = 0; i < NumPorts; i++) begin
        cand = arb_mode_i ? i : (int'(rr_ptr) + i) % NumPorts;
        if (!gnt_valid && eligible[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = PortIdxWidth'(cand);
        end
      end
    end
  end

  always_comb begin
    slv_req_ready_o = '0;
    if (gnt_valid) slv_req_ready_o[gnt_idx] = 1'b1;
  end

  // Responses carrying an index beyond the last port are swallowed so the master never stalls.
  assign rsp_idx    = mst_rsp_id_i[MstIdWidth-1:IdWidth];
  assign rsp_idx_ok = int'(rsp_idx) < NumPorts;

  always_comb begin
    slv_rsp_valid_o = '0;
    mst_rsp_ready_o = 1'b0;
    if (!rst_i) begin
      if (rsp_idx_ok) begin
        slv_rsp_valid_o[rsp_idx] = mst_rsp_valid_i;
        mst_rsp_ready_o          = slv_rsp_ready_i[rsp_idx];
      end else begin
        mst_rsp_ready_o = 1'b1;
      end
    end
  end

  assign rsp_hs         = mst_rsp_valid_i && mst_rsp_ready_o;
  assign slv_rsp_data_o = rst_i ? '0 : mst_rsp_data_i;
  assign slv_rsp_id_o   = rst_i ? '0 : mst_rsp_id_i[IdWidth-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mst_req_valid_o <= 1'b0;
      mst_req_addr_o  <= '0;
      mst_req_data_o  <= '0;
      mst_req_we_o    <= 1'b0;
      mst_req_id_o    <= '0;
      rr_ptr          <= '0;
      cnt             <= '0;
      err_o           <= 1'b0;
      drained_o       <= drain_i;
    end else begin
      if (gnt_valid) begin
        mst_req_valid_o <= 1'b1;
        mst_req_addr_o  <= slv_req_addr_i[gnt_idx];
        mst_req_data_o  <= slv_req_data_i[gnt_idx];
        mst_req_we_o    <= slv_req_we_i[gnt_idx];
        mst_req_id_o    <= {gnt_idx, slv_req_id_i[gnt_idx]};
        if (!arb_mode_i)
          rr_ptr <= (int'(gnt_idx) == NumPorts - 1) ? '0 : gnt_idx + 1'b1;
      end else if (mst_req_ready_i) begin
        mst_req_valid_o <= 1'b0;
      end

      for (int p = 0; p < NumPorts; p++) begin
        if (gnt_valid && gnt_idx == PortIdxWidth'(p)) begin
          if (!(rsp_hs && rsp_idx == PortIdxWidth'(p))) cnt[p] <= cnt[p] + 1'b1;
        end else if (rsp_hs && rsp_idx == PortIdxWidth'(p)) begin
          if (cnt[p] != '0) cnt[p] <= cnt[p] - 1'b1;
          else              err_o  <= 1'b1;
        end
      end
      if (rsp_hs && !rsp_idx_ok) err_o <= 1'b1;

      drained_o <= drain_i && all_idle && !mst_req_valid_o;
    end
  end

endmodule

// File: tb/tb_carfield_vip_req_mux.sv
// Directed bench for carfield_vip_req_mux with four ports and three outstanding
// transactions per port; expected values are worked out by hand for each step.
module tb_carfield_vip_req_mux;

  localparam int NP = 4;
  localparam int IW = 4;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int MT = 3;
  localparam int MIW = IW + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   arb_mode;
  logic                   drain;
  logic                   drained;
  logic                   err;
  logic [NP-1:0]          req_valid;
  logic [NP-1:0]          req_ready;
  logic [NP-1:0][AW-1:0]  req_addr;
  logic [NP-1:0][DW-1:0]  req_data;
  logic [NP-1:0]          req_we;
  logic [NP-1:0][IW-1:0]  req_id;
  logic [NP-1:0]          rsp_valid;
  logic [NP-1:0]          rsp_ready;
  logic [DW-1:0]          rsp_data;
  logic [IW-1:0]          rsp_id;
  logic                   m_req_valid;
  logic                   m_req_ready;
  logic [AW-1:0]          m_req_addr;
  logic [DW-1:0]          m_req_data;
  logic                   m_req_we;
  logic [MIW-1:0]         m_req_id;
  logic                   m_rsp_valid;
  logic                   m_rsp_ready;
  logic [DW-1:0]          m_rsp_data;
  logic [MIW-1:0]         m_rsp_id;

  int checks = 0;
  int errors = 0;

  carfield_vip_req_mux #(
    .NumPorts(NP), .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .MaxTxns(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .arb_mode_i(arb_mode), .drain_i(drain),
    .drained_o(drained), .err_o(err),
    .slv_req_valid_i(req_valid), .slv_req_ready_o(req_ready),
    .slv_req_addr_i(req_addr), .slv_req_data_i(req_data),
    .slv_req_we_i(req_we), .slv_req_id_i(req_id),
    .slv_rsp_valid_o(rsp_valid), .slv_rsp_ready_i(rsp_ready),
    .slv_rsp_data_o(rsp_data), .slv_rsp_id_o(rsp_id),
    .mst_req_valid_o(m_req_valid), .mst_req_ready_i(m_req_ready),
    .mst_req_addr_o(m_req_addr), .mst_req_data_o(m_req_data),
    .mst_req_we_o(m_req_we), .mst_req_id_o(m_req_id),
    .mst_rsp_valid_i(m_rsp_valid), .mst_rsp_ready_o(m_rsp_ready),
    .mst_rsp_data_i(m_rsp_data), .mst_rsp_id_i(m_rsp_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arb_mode = 1'b0; drain = 1'b0;
    req_valid = '0; req_we = '0; m_req_ready = 1'b0;
    m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_id = '0; rsp_ready = '0;
    for (int p = 0; p < NP; p++) begin
      req_addr[p] = 48'h1000 * (p + 1);
      req_data[p] = 64'hD0 + 64'(p);
      req_id[p]   = IW'(p + 5);
      req_we[p]   = p[0];
    end

    // reset state
    tick(); tick();
    chk("rst_mvalid", 64'(m_req_valid), 0);
    chk("rst_sready", 64'(req_ready), 0);
    chk("rst_mrready", 64'(m_rsp_ready), 0);
    chk("rst_rvalid", 64'(rsp_valid), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_drained", 64'(drained), 0);
    rst = 1'b0;

    // round-robin, all ports valid, one request per cycle
    req_valid = 4'hF; m_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_gnt", 64'(req_ready), 64'(1 << (i % 4)));
      tick();
      chk("rr_mvalid", 64'(m_req_valid), 1);
      chk("rr_id", 64'(m_req_id), 64'((i % 4) * 16 + (i % 4) + 5));
      chk("rr_addr", 64'(m_req_addr), 64'(48'h1000 * ((i % 4) + 1)));
    end
    // back-pressure holds the payload and blocks acceptance
    m_req_ready = 1'b0;
    #1 chk("bp_sready", 64'(req_ready), 0);
    tick();
    chk("bp_mvalid", 64'(m_req_valid), 1);
    chk("bp_id", 64'(m_req_id), 64'(3 * 16 + 8));
    chk("bp_data", m_req_data, 64'hD3);
    m_req_ready = 1'b1;
    #1 chk("bp_release", 64'(req_ready), 64'b0001);
    req_valid = '0;
    tick();
    do_reset();

    // fixed priority: port 1 beats port 3 until it drops valid
    arb_mode = 1'b1; req_valid = 4'b1010;
    #1 chk("fp_gnt0", 64'(req_ready), 64'b0010);
    tick();
    chk("fp_gnt1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b1000;
    #1 chk("fp_gnt3", 64'(req_ready), 64'b1000);
    tick();
    chk("fp_id", 64'(m_req_id), 64'(3 * 16 + 8));

    // port 1 fills to MaxTxns, one response frees a slot
    arb_mode = 1'b0; req_valid = 4'b0010;
    #1 chk("max_gnt", 64'(req_ready), 64'b0010);
    tick();
    chk("max_full", 64'(req_ready), 0);
    m_rsp_valid = 1'b1; m_rsp_id = 6'h13; rsp_ready = 4'hF; m_rsp_data = 64'hBEEF;
    #1;
    chk("max_rvalid", 64'(rsp_valid), 64'b0010);
    chk("max_mrready", 64'(m_rsp_ready), 1);
    chk("max_still_full", 64'(req_ready), 0);
    tick();
    m_rsp_valid = 1'b0;
    #1 chk("max_freed", 64'(req_ready), 64'b0010);
    req_valid = '0;
    tick();

    // response routing and slave back-pressure
    m_rsp_valid = 1'b1; m_rsp_id = 6'h25; rsp_ready = 4'b1011;
    #1;
    chk("route_valid", 64'(rsp_valid), 64'b0100);
    chk("route_id", 64'(rsp_id), 5);
    chk("route_data", rsp_data, 64'hBEEF);
    chk("route_stall", 64'(m_rsp_ready), 0);
    m_rsp_valid = 1'b0;
    tick();
    chk("route_noerr", 64'(err), 0);
    do_reset();

    // drain with three outstanding on port 1
    rsp_ready = 4'hF; req_valid = 4'b0010;
    tick(); tick(); tick();
    req_valid = 4'hF; drain = 1'b1;
    #1 chk("drn_block", 64'(req_ready), 0);
    tick();
    chk("drn_mvalid", 64'(m_req_valid), 0);
    chk("drn_busy", 64'(drained), 0);
    m_rsp_valid = 1'b1; m_rsp_id = 6'h10;
    tick(); tick();
    chk("drn_busy2", 64'(drained), 0);
    tick();
    chk("drn_lag", 64'(drained), 0);
    m_rsp_valid = 1'b0;
    tick();
    chk("drn_done", 64'(drained), 1);
    chk("drn_nogrant", 64'(m_req_valid), 0);

    // response to an idle port sets the sticky error
    drain = 1'b0; req_valid = '0;
    m_rsp_valid = 1'b1; m_rsp_id = 6'h31;
    #1;
    chk("err_rvalid", 64'(rsp_valid), 64'b1000);
    chk("err_mrready", 64'(m_rsp_ready), 1);
    tick();
    m_rsp_valid = 1'b0;
    chk("err_set", 64'(err), 1);
    tick();
    chk("err_sticky", 64'(err), 1);

    // reset mid-burst drops everything
    req_valid = 4'hF;
    tick();
    chk("burst_mvalid", 64'(m_req_valid), 1);
    rst = 1'b1;
    #1 chk("rst_comb_ready", 64'(req_ready), 0);
    tick();
    chk("rst2_mvalid", 64'(m_req_valid), 0);
    chk("rst2_err", 64'(err), 0);
    chk("rst2_drained", 64'(drained), 0);
    drain = 1'b1;
    tick();
    chk("rst_drain_hi", 64'(drained), 1);
    drain = 1'b0; rst = 1'b0;
    #1 chk("post_rst_gnt", 64'(req_ready), 64'b0001);
    tick();
    chk("post_rst_id", 64'(m_req_id), 5);
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
